// File: rtl/mult_arbiter_if.sv
// Request/operand bus between the equalizer gain stages and the shared
// saturating multiplier.
interface mult_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int Width = 16,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*Width-1:0] a_bus;
    logic [NREQ*Width-1:0] b_bus;
    logic [Width-1:0]      y;
    logic [NREQ-1:0]       done;
    logic                  sat;
    logic [IDW-1:0]        grant_id;
    logic                  busy;

    modport master (
        output req, a_bus, b_bus,
        input  y, done, sat, grant_id, busy
    );

    modport slave (
        input  req, a_bus, b_bus,
        output y, done, sat, grant_id, busy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter time-sharing one saturating signed Q(Width-f).f
// multiplier among NREQ requesters; one operation every three cycles.
module mult_arbiter #(
    parameter int NREQ  = 4,
    parameter int Width = 16,
    parameter int f     = 10,
    parameter int IDW   = 2
) (
    input logic           clk,
    input logic           reset,
    mult_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        MUL,
        RESP
    } state_e;

    localparam int PW = 2 * Width;
    localparam logic signed [PW-1:0] RMAX =
        {{(Width + 1){1'b0}}, {(Width - 1){1'b1}}};
    localparam logic signed [PW-1:0] RMIN =
        {{(Width + 1){1'b1}}, {(Width - 1){1'b0}}};
    localparam logic [Width-1:0] YMAX = {1'b0, {(Width - 1){1'b1}}};
    localparam logic [Width-1:0] YMIN = {1'b1, {(Width - 1){1'b0}}};

    state_e                  state_q, state_d;
    logic [IDW-1:0]          last_q, last_d;
    logic [IDW-1:0]          gid_q, gid_d;
    logic signed [Width-1:0] a_q, a_d;
    logic signed [Width-1:0] b_q, b_d;
    logic [Width-1:0]        y_q, y_d;
    logic                    sat_q, sat_d;

    logic                    found;
    logic [IDW-1:0]          win;
    logic [IDW-1:0]          idx;
    logic signed [Width-1:0] a_sel;
    logic signed [Width-1:0] b_sel;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    res;

    // Scan starts just past the last winner so it gets lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (win == IDW'(j)) begin
                a_sel = bus.a_bus[j*Width +: Width];
                b_sel = bus.b_bus[j*Width +: Width];
            end
        end
    end

    assign prod = PW'(a_q) * PW'(b_q);
    // Arithmetic shift truncates toward minus infinity.
    assign res  = prod >>> f;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gid_d   = gid_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = MUL;
                    last_d  = win;
                    gid_d   = win;
                    a_d     = a_sel;
                    b_d     = b_sel;
                end
            end
            MUL: begin
                state_d = RESP;
                if (res > RMAX) begin
                    y_d   = YMAX;
                    sat_d = 1'b1;
                end else if (res < RMIN) begin
                    y_d   = YMIN;
                    sat_d = 1'b1;
                end else begin
                    y_d   = res[Width-1:0];
                    sat_d = 1'b0;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            gid_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.y        = y_q;
    assign bus.sat      = sat_q && (state_q == RESP);
    assign bus.grant_id = gid_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == RESP) ? (NREQ'(1) << gid_q) : '0;
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized bench for mult_arbiter against a transaction-level model
// of the round-robin grant order and saturating fixed-point product.
module tb_mult_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int F    = 10;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_arbiter_if #(.NREQ(NREQ), .Width(W), .IDW(IDW)) bus ();

    mult_arbiter #(
        .NREQ (NREQ),
        .Width(W),
        .f    (F),
        .IDW  (IDW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int last_m;

    logic [W-1:0]    opa[NREQ];
    logic [W-1:0]    opb[NREQ];
    logic [NREQ-1:0] req_m;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            if (m[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic void ref_mul(input logic [W-1:0] a,
                                    input logic [W-1:0] b,
                                    output logic [W-1:0] y,
                                    output logic s);
        longint p, r, scale, maxv, minv;
        scale = longint'(1) << F;
        maxv  = (longint'(1) << (W - 1)) - 1;
        minv  = -(longint'(1) << (W - 1));
        p = longint'($signed(a)) * longint'($signed(b));
        r = p / scale;
        if (p < 0 && (p % scale) != 0) r = r - 1;
        if (r > maxv) begin
            y = 16'h7FFF;
            s = 1'b1;
        end else if (r < minv) begin
            y = 16'h8000;
            s = 1'b1;
        end else begin
            y = r[W-1:0];
            s = 1'b0;
        end
    endfunction

    task automatic apply();
        bus.req = req_m;
        for (int j = 0; j < NREQ; j++) begin
            bus.a_bus[j*W +: W] = opa[j];
            bus.b_bus[j*W +: W] = opb[j];
        end
    endtask

    // Called #1 into an IDLE cycle with a nonzero request mask applied.
    task automatic op();
        int w;
        logic [W-1:0] ey;
        logic es;
        w = pick(req_m, last_m);
        ref_mul(opa[w], opb[w], ey, es);
        @(posedge clk); #1;
        last_m = w;
        chk("busy_mul", 32'(bus.busy), 1);
        chk("grant_id", 32'(bus.grant_id), w);
        chk("done_mul", 32'(bus.done), 0);
        for (int j = 0; j < NREQ; j++) begin
            opa[j] = W'($urandom);
            opb[j] = W'($urandom);
        end
        apply();
        @(posedge clk); #1;
        chk("done", 32'(bus.done), 1 << w);
        chk("y", 32'(bus.y), 32'(ey));
        chk("sat", 32'(bus.sat), 32'(es));
        chk("busy_resp", 32'(bus.busy), 1);
        req_m[w] = 1'b0;
        apply();
        @(posedge clk); #1;
        chk("done_idle", 32'(bus.done), 0);
        chk("busy_idle", 32'(bus.busy), 0);
        chk("y_hold", 32'(bus.y), 32'(ey));
    endtask

    task automatic dir(input int r, input logic [W-1:0] a,
                       input logic [W-1:0] b);
        opa[r] = a;
        opb[r] = b;
        req_m  = NREQ'(1) << r;
        apply();
        op();
    endtask

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] edges[6];
        edges = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0400, 16'hFC00};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return W'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req_m = '0;
        for (int j = 0; j < NREQ; j++) begin
            opa[j] = '0;
            opb[j] = '0;
        end
        apply();
        last_m = NREQ - 1;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_sat", 32'(bus.sat), 0);
        chk("rst_gid", 32'(bus.grant_id), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_done", 32'(bus.done), 0);

        dir(0, 16'h0600, 16'h0800);
        dir(2, 16'h4000, 16'h0800);
        dir(1, 16'hC000, 16'h0800);
        dir(3, 16'hC000, 16'h0C00);
        dir(0, 16'hFFFF, 16'h0200);
        dir(2, 16'h0000, 16'h8000);

        // Abort an operation for requester 1 while it is in MUL.
        opa[1] = 16'h0600;
        opb[1] = 16'h0800;
        req_m  = 4'b0010;
        apply();
        @(posedge clk); #1;
        chk("mid_busy", 32'(bus.busy), 1);
        chk("mid_gid", 32'(bus.grant_id), 1);
        reset = 1'b1;
        #1;
        chk("mrst_y", 32'(bus.y), 0);
        chk("mrst_done", 32'(bus.done), 0);
        chk("mrst_sat", 32'(bus.sat), 0);
        chk("mrst_gid", 32'(bus.grant_id), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        last_m = NREQ - 1;
        req_m  = '0;
        apply();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("no_done", 32'(bus.done), 0);
        end
        req_m = 4'b0011;
        apply();
        op();
        req_m = '0;
        apply();

        // All requesters held; each re-raises one cycle after its done.
        req_m = '1;
        for (int j = 0; j < NREQ; j++) begin
            opa[j] = rnd_op();
            opb[j] = rnd_op();
        end
        apply();
        for (int k = 0; k < 6; k++) begin
            op();
            req_m = '1;
            apply();
        end
        req_m = '0;
        apply();
        @(posedge clk); #1;

        for (int k = 0; k < 40; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                opa[j] = rnd_op();
                opb[j] = rnd_op();
            end
            req_m = req_m | NREQ'($urandom_range(0, 15));
            if (req_m == '0) req_m = NREQ'(1) << $urandom_range(0, NREQ - 1);
            apply();
            op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
